// File: rtl/add_sub_serial_if.sv
// Handshake and data bundle for the chunk-serial adder/subtractor.
// master: issues operations and consumes results; slave: the arithmetic unit.
interface add_sub_serial_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, res, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, res, cout, ovf, zero
  );
endinterface

// File: rtl/add_sub_serial.sv
// Chunk-serial two's-complement adder/subtractor.
// Processes CHUNK bits per clock, WIDTH/CHUNK clocks per operation, with a
// valid/ready handshake on both the operand side and the result side.
module add_sub_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic             clk,
  input logic             rst_n,
  add_sub_serial_if.slave bus
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("add_sub_serial: need WIDTH >= 2, 1 <= CHUNK <= WIDTH, WIDTH %% CHUNK == 0");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sub;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_res;
  logic             r_cout;
  logic             r_ovf;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]   w_sum;
  logic             w_cin_msb;
  logic [WIDTH-1:0] w_a_rot;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_last = (r_idx == IDXW'(N - 1));

  // Current chunk sum; r_a doubles as the result accumulator: each step shifts
  // the consumed A chunk out of the bottom and the new sum chunk in at the top,
  // so after N steps r_a holds the complete result in order.
  always_comb begin
    w_a_chunk = r_a[CHUNK-1:0];
    w_b_chunk = r_b[CHUNK-1:0] ^ {CHUNK{r_sub}};
    w_sum     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
    w_cin_msb = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_sum[CHUNK-1];
    w_a_rot   = (r_a >> CHUNK) | (WIDTH'(w_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
  end

  // Operand capture, per-chunk progress and result/flag capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_res   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_sub   <= bus.sub;
      r_carry <= bus.sub;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= w_a_rot;
      r_b     <= r_b >> CHUNK;
      r_carry <= w_sum[CHUNK];
      r_idx   <= w_last ? '0 : r_idx + 1'b1;
      if (w_last) begin
        r_res  <= w_a_rot;
        r_cout <= w_sum[CHUNK];
        r_ovf  <= w_cin_msb ^ w_sum[CHUNK];
      end
    end
  end

  assign bus.res  = r_res;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
  assign bus.zero = (r_res == '0);

endmodule

// File: doc/add_sub_serial.md
ADD_SUB_SERIAL -- requirements
Module: add_sub_serial

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits; SHALL be >= 2.
REQ-002 Parameter CHUNK, default 4, bits processed per cycle; SHALL satisfy 1 <= CHUNK <= WIDTH and WIDTH % CHUNK == 0, else elaboration SHALL fail.
REQ-003 One clock; reset is synchronous and active-low; ports named clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  operands and mode presented.
REQ-007 in_ready  output  1  block can accept an operation.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 sub  input  1  0 = A+B, 1 = A-B (two's complement: A + ~B + 1).
REQ-011 out_valid  output  1  result and flags valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 res  output  WIDTH  sum/difference modulo 2^WIDTH.
REQ-014 cout  output  1  carry out of MSB (for subtract: 1 = no borrow, A >= B unsigned).
REQ-015 ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
REQ-016 zero  output  1  res == 0.

Function
REQ-017 FSM states IDLE, RUN, DONE; N = WIDTH/CHUNK.
REQ-018 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-019 Accept = in_valid & in_ready at a rising edge: register a, b, sub; carry register := sub; chunk index := 0; state -> RUN.
REQ-020 Operand inputs SHALL be ignored outside the accept edge; changes during RUN/DONE do not affect the result.
REQ-021 In RUN, each edge SHALL compute chunk k: res[k*CHUNK +: CHUNK] = A_chunk + (B_chunk XOR {CHUNK{sub}}) + carry; carry register := chunk carry out; k := k+1.
REQ-022 On the edge processing chunk N-1: capture cout = final carry, ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, state -> DONE.
REQ-023 Latency: out_valid SHALL rise exactly N edges after the accept edge (CHUNK = WIDTH gives N = 1).
REQ-024 zero SHALL be derived from the completed res and be valid whenever out_valid = 1.
REQ-025 In DONE, res/cout/ovf/zero SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-026 DONE with out_ready = 1 at an edge: state -> IDLE; in_ready = 1 the following cycle; no new accept in the same edge.
REQ-027 Maximum throughput: one operation per N+2 cycles.
REQ-028 Arithmetic SHALL be bit-exact to (A + B) mod 2^WIDTH or (A - B) mod 2^WIDTH for all operands.
REQ-029 res, cout, ovf SHALL retain the last completed values in IDLE until the next completion overwrites them.

Reset
REQ-030 rst_n = 0 at a rising edge: state -> IDLE, chunk index 0, carry 0, res 0, cout 0, ovf 0; hence in_ready = 1, out_valid = 0, zero = 1 from the next cycle.
REQ-031 Reset SHALL take priority over accept, RUN progress and DONE handshake; an in-flight operation is discarded with no out_valid pulse.
REQ-032 in_valid asserted during reset SHALL not be accepted.

Verification (WIDTH=16, CHUNK=4 unless noted)
REQ-033 Add: a=0x1234, b=0x0FFF, sub=0 -> out_valid 4 edges after accept, res=0x2233, cout=0, ovf=0, zero=0.
REQ-034 Subtract wrap/borrow: a=0x0001, b=0x0002, sub=1 -> res=0xFFFF, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> res=0x7FFF, cout=1, ovf=1.
REQ-035 Zero/overflow: a=0x7FFF, b=0x0001, sub=0 -> res=0x8000, ovf=1, cout=0; a=0xFFFF, b=0x0001, sub=0 -> res=0x0000, cout=1, zero=1, ovf=0.
REQ-036 Backpressure: out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0; out_ready=1 -> IDLE next cycle; operands changed during RUN do not alter res.
REQ-037 Reset mid-operation: rst_n=0 on second RUN edge -> next cycle in_ready=1, out_valid=0, res=0; new operation afterwards completes correctly.
REQ-038 Parameter sweep CHUNK in {1,4,16}: 1000 random operands per mode match reference model; latency equals 16, 4, 1 edges respectively.
